// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
//   Eight-way arbiter with a registered one-hot grant, a per-grant hold limit,
//   and a pulse that flags grants withdrawn by that limit.
//
// Handshake: a requester asks by holding req[i] high (level, no pulse). The
//   grant appears on gnt one cycle after req is sampled in IDLE. The owner
//   keeps the grant while it holds req[i] high. It gives the grant back by
//   pulsing done or by dropping req[i]. If it does neither, the grant is taken
//   back after HOLD_MAX visible cycles and revoked pulses for one cycle.
//   At least one IDLE cycle always separates two grants.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[7:0]   request lines, bit i = requester i
//   done       owner release strobe, ignored while IDLE
//   gnt[7:0]   registered grant, one-hot or zero
//   busy       registered, high while gnt is non-zero
//   revoked    registered one-cycle pulse after a hold-timeout withdrawal
//   state_dbg  current FSM state (0 = IDLE, 1 = GRANT) for observation
//
// Parameter:
//   HOLD_MAX   maximum number of visible cycles per grant (1..255)
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, the lowest asserted request index wins.
//                      When not defined, selection is round-robin starting
//                      after the last owner.
module onehot_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       revoked,
  output logic       state_dbg
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  // Counter value seen during the last permitted visible cycle of a grant.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       revoked_q, revoked_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] last_q, last_d;

  logic       win_valid;
  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       owner_req;
  logic       timeout;

  // Winner selection. This logic is only used while IDLE.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
`ifdef ARB_FIXED_PRIO_EN
    // Scan from the top down so that the lowest asserted index wins.
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
      end
    end
`else
    // Scan upward from last+1. The 3-bit add wraps 7 to 0. The eighth
    // candidate is the last owner itself.
    for (int i = 1; i <= 8; i++) begin
      cand = last_q + 3'(i);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  // last_q holds the current owner's index for the whole GRANT state.
  assign owner_req = req[last_q];
  assign timeout   = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    revoked_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = 8'h00;
        busy_d = 1'b0;
        cnt_d  = 8'd0;
        if (win_valid) begin
          state_d = S_GRANT;
          gnt_d   = 8'h01 << win_idx;
          busy_d  = 1'b1;
          last_d  = win_idx;
        end
      end
      S_GRANT: begin
        if (done || !owner_req || timeout) begin
          state_d   = S_IDLE;
          gnt_d     = 8'h00;
          busy_d    = 1'b0;
          cnt_d     = 8'd0;
          // Report only a pure timeout. A release in the same cycle takes
          // precedence and counts as a normal release.
          revoked_d = timeout && !done && owner_req;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 8'h00;
      busy_q    <= 1'b0;
      revoked_q <= 1'b0;
      cnt_q     <= 8'd0;
      last_q    <= 3'd7;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      revoked_q <= revoked_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign revoked   = revoked_q;
  assign state_dbg = (state_q == S_GRANT);

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
module tb_onehot_rr_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       busy;
  logic       revoked;
  logic       state_dbg;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .busy      (busy),
    .revoked   (revoked),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  // Each entry holds {gnt, revoked}. busy is expected to equal |gnt.
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // ---------------- driver ----------------
  // Apply inputs for one clock edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] e_gnt, input logic e_rev);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    exp_q.push_back({e_gnt, e_rev});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL onehot: gnt=%h has more than one bit set", gnt);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e[8:1]) begin
          errors++;
          $display("FAIL gnt @%0t: got %h expected %h", $time, gnt, e[8:1]);
        end
        checks++;
        if (busy !== (|e[8:1])) begin
          errors++;
          $display("FAIL busy @%0t: got %b expected %b", $time, busy, |e[8:1]);
        end
        checks++;
        if (revoked !== e[0]) begin
          errors++;
          $display("FAIL revoked @%0t: got %b expected %b", $time, revoked, e[0]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] exp_w;

  initial begin : stim
    // Reset state.
    step(1, 8'h00, 0, 8'h00, 0);
    step(1, 8'h00, 0, 8'h00, 0);

    // Single requester. The grant appears one cycle after req and is
    // released by done in its third visible cycle.
    step(0, 8'h01, 0, 8'h01, 0);
    step(0, 8'h01, 0, 8'h01, 0);
    step(0, 8'h01, 0, 8'h01, 0);
    step(0, 8'h01, 1, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);
    // done while IDLE has no effect.
    step(0, 8'h00, 1, 8'h00, 0);

    // All requesting, done on every grant: rotation 01..80 then back to 01.
    step(1, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_w = 8'h01;
`else
      exp_w = 8'h01 << (i % 8);
`endif
      step(0, 8'hFF, 0, exp_w, 0);
      step(0, 8'hFF, 1, 8'h00, 0);
    end

    // Hold timeout with HOLD_MAX=4: four visible cycles, then a revoke
    // pulse, then a re-grant.
    step(1, 8'h00, 0, 8'h00, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h00, 1);
    step(0, 8'h10, 0, 8'h10, 0);
    // done coincides with timeout: this is a normal release, so no revoke.
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 0, 8'h10, 0);
    step(0, 8'h10, 1, 8'h00, 0);
    step(0, 8'h00, 0, 8'h00, 0);

    // Owner drops req[2] with req[5] pending: a plain release, then bit 5
    // wins because the search starts at bit 3.
    step(1, 8'h00, 0, 8'h00, 0);
    step(0, 8'h04, 0, 8'h04, 0);
    step(0, 8'h24, 0, 8'h04, 0);
    step(0, 8'h20, 0, 8'h00, 0);
`ifdef ARB_FIXED_PRIO_EN
    step(0, 8'h24, 0, 8'h04, 0);
`else
    step(0, 8'h24, 0, 8'h20, 0);
`endif
    step(0, 8'h00, 1, 8'h00, 0);

    // Reset during a grant aborts it with no revoke and sets the pointer
    // back to 7, so 8'h88 grants bit 3 rather than bit 7.
    step(1, 8'h00, 0, 8'h00, 0);
    step(0, 8'h08, 0, 8'h08, 0);
    step(0, 8'h08, 0, 8'h08, 0);
    step(1, 8'h08, 0, 8'h00, 0);
    step(0, 8'h88, 0, 8'h08, 0);
    step(0, 8'h88, 1, 8'h00, 0);
    step(1, 8'h00, 0, 8'h00, 0);

    // Drain the queue within a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_rr_arbiter.md
ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 16, max consecutive cycles one grant may be held (legal 1..255).
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  request lines, bit i = requester i, level-sensitive.
REQ-005 done  input  1  owner release strobe, sampled only while a grant is active.
REQ-006 gnt  output  8  registered grant, one-hot or all-zero; feeds the downstream 8-to-3 encoder.
REQ-007 busy  output  1  registered, high exactly when gnt is non-zero.
REQ-008 revoked  output  1  registered one-cycle pulse when a grant is withdrawn by hold timeout.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE (gnt=0) and GRANT (gnt one-hot).
REQ-010 IDLE, req==0: remain IDLE, outputs unchanged at zero.
REQ-011 IDLE, req!=0: select winner, load gnt with its one-hot bit at the next edge, enter GRANT; grant visible one cycle after req is sampled.
REQ-012 Winner selection: round-robin, search ascending from (last+1) mod 8 with wrap 7->0; first asserted bit wins.
REQ-013 last (3-bit owner pointer) SHALL update to the winner index on the same edge gnt is loaded.
REQ-014 GRANT: gnt held constant; hold counter (8-bit) increments every GRANT cycle, cleared on entry.
REQ-015 GRANT exit conditions, any of: done==1; req[owner]==0; counter reached HOLD_MAX-1 (i.e. grant has been visible HOLD_MAX cycles).
REQ-016 On exit, gnt and busy SHALL clear at the next edge and FSM returns to IDLE; no grant-to-grant back-to-back, minimum one IDLE cycle between grants.
REQ-017 revoked SHALL pulse high for the one cycle following a timeout exit, only when neither done nor req[owner] drop caused the exit in the same cycle.
REQ-018 Simultaneous done and timeout: treat as normal release, revoked stays 0.
REQ-019 New requests arriving during GRANT SHALL be ignored until the next IDLE cycle; no queuing.
REQ-020 done sampled in IDLE SHALL have no effect.
REQ-021 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-022 rst high at a clock edge: state=IDLE, gnt=8'h00, busy=0, revoked=0, counter=0, last=3'd7 (first round-robin search starts at bit 0).
REQ-023 rst asserted mid-GRANT SHALL abort the grant at that edge with no revoked pulse; rst dominates all other inputs.

Configuration
REQ-024 Macro ARB_FIXED_PRIO_EN: when defined, winner selection SHALL be fixed priority (lowest asserted index wins, last pointer unused); when undefined, round-robin per REQ-012.
REQ-025 HOLD_MAX timeout, FSM and all ports SHALL be identical in both builds.

Verification
REQ-026 rst, then req=8'h01 held, done pulsed 3 cycles after grant -> gnt=8'h01 one cycle after req, clears one cycle after done, busy tracks gnt.
REQ-027 req=8'hFF held, done each grant -> grant sequence 01,02,04,...,80,01 (wrap), one idle cycle between each; with ARB_FIXED_PRIO_EN -> 01 every grant.
REQ-028 HOLD_MAX=4, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 4 cycles, then gnt=0 and revoked=1 for one cycle, then re-grant 8'h10.
REQ-029 Grant to bit 2, drop req[2] -> gnt clears next edge, revoked=0; req=8'h24 pending -> next grant 8'h20.
REQ-030 rst pulsed during GRANT of 8'h08 -> gnt=0, revoked=0 next cycle; next req=8'h88 grants 8'h08 (pointer reset to 7).
